// File: rtl/pipe_buf_pkg.sv
// Shared constants and helpers for the elastic pipeline register.
package pipe_buf_pkg;

  localparam int unsigned BubbleW = 16;
  localparam logic [BubbleW-1:0] BubbleMax = 16'hFFFF;

  // A single-entry buffer still needs a 1-bit pointer, pinned at zero.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buf_if.sv
// Upstream/downstream valid-ready handshake bundle of one pipeline boundary.
interface pipe_buf_if #(
  parameter int unsigned DATA_W = 104
) ();

  logic              up_valid_in;
  logic [DATA_W-1:0] up_data_in;
  logic              up_ready_out;
  logic              dn_valid_out;
  logic [DATA_W-1:0] dn_data_out;
  logic              dn_ready_in;

  modport master (
    output up_valid_in, up_data_in, dn_ready_in,
    input  up_ready_out, dn_valid_out, dn_data_out
  );

  modport slave (
    input  up_valid_in, up_data_in, dn_ready_in,
    output up_ready_out, dn_valid_out, dn_data_out
  );

endinterface

// File: rtl/pipe_buf.sv
// Elastic pipeline register: DEPTH-entry FIFO with valid/ready flow control,
// flush, global freeze and a saturating downstream bubble counter.
module pipe_buf
  import pipe_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 104,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  pipe_buf_if.slave          bus,
  output logic [CNT_W-1:0]   count_out,
  output logic [BubbleW-1:0] bubble_cnt_out
);

  localparam int unsigned PtrW = ptr_width(DEPTH);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BubbleW-1:0] bubble_q, bubble_d;
  logic               full, empty, push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Handshakes depend only on registered state and rdy_in.
  assign bus.up_ready_out = rdy_in & ~full;
  assign bus.dn_valid_out = rdy_in & ~empty;
  assign bus.dn_data_out  = bus.dn_valid_out ? mem_q[rd_ptr_q] : '0;

  assign push = bus.up_valid_in & bus.up_ready_out & ~flush_in;
  assign pop  = bus.dn_valid_out & bus.dn_ready_in & ~flush_in;

  assign count_out      = count_q;
  assign bubble_cnt_out = bubble_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    bubble_d = bubble_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (DEPTH > 1) ? wr_ptr_q + PtrW'(1) : '0;
      end
      if (pop) begin
        rd_ptr_d = (DEPTH > 1) ? rd_ptr_q + PtrW'(1) : '0;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (rdy_in && bus.dn_ready_in && !bus.dn_valid_out && bubble_q != BubbleMax) begin
        bubble_d = bubble_q + BubbleW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bubble_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bubble_q <= bubble_d;
    end
  end

  // Storage needs no reset; entries are only observable once counted.
  always_ff @(posedge clk_in) begin
    if (rst_in && push) begin
      mem_q[wr_ptr_q] <= bus.up_data_in;
    end
  end

endmodule

// File: tb/tb_pipe_buf.sv
// Drives a DEPTH=2 and a DEPTH=1 pipe_buf with shared stimulus, each checked
// against a queue-based reference model.
module tb_pipe_buf;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, rdy, flush, up_valid, dn_ready;
  logic [DW-1:0] up_data;
  logic [1:0]    cnt2;
  logic [0:0]    cnt1;
  logic [15:0]   bub2, bub1;
  logic          mon_en = 1'b0;
  int unsigned   total = 0, passed = 0;

  always #5 clk = ~clk;

  pipe_buf_if #(.DATA_W(DW)) bus2 ();
  pipe_buf_if #(.DATA_W(DW)) bus1 ();

  assign bus2.up_valid_in = up_valid;
  assign bus2.up_data_in  = up_data;
  assign bus2.dn_ready_in = dn_ready;
  assign bus1.up_valid_in = up_valid;
  assign bus1.up_data_in  = up_data;
  assign bus1.dn_ready_in = dn_ready;

  pipe_buf #(.DATA_W(DW), .DEPTH(2)) dut2 (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush), .bus(bus2),
    .count_out(cnt2), .bubble_cnt_out(bub2)
  );

  pipe_buf #(.DATA_W(DW), .DEPTH(1)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush), .bus(bus1),
    .count_out(cnt1), .bubble_cnt_out(bub1)
  );

  // Reference model: the queue holds exactly the payloads still owed downstream.
  logic [DW-1:0] q2[$], q1[$];
  int unsigned   b2 = 0, b1 = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q2.delete(); q1.delete(); b2 = 0; b1 = 0;
    end else if (flush) begin
      q2.delete(); q1.delete();
    end else if (rdy) begin
      automatic bit pop2  = dn_ready && q2.size() != 0;
      automatic bit push2 = up_valid && q2.size() < 2;
      automatic bit pop1  = dn_ready && q1.size() != 0;
      automatic bit push1 = up_valid && q1.size() < 1;
      if (dn_ready && q2.size() == 0 && b2 < 65535) b2++;
      if (dn_ready && q1.size() == 0 && b1 < 65535) b1++;
      if (pop2) void'(q2.pop_front());
      if (push2) q2.push_back(up_data);
      if (pop1) void'(q1.pop_front());
      if (push1) q1.push_back(up_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // Monitor: compares every presented output against the model head.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready2", 32'(bus2.up_ready_out), 32'(rdy && q2.size() < 2));
      chk("valid2", 32'(bus2.dn_valid_out), 32'(rdy && q2.size() != 0));
      chk("data2", bus2.dn_data_out, (rdy && q2.size() != 0) ? q2[0] : 32'h0);
      chk("count2", 32'(cnt2), 32'(q2.size()));
      chk("bubble2", 32'(bub2), b2);
      chk("ready1", 32'(bus1.up_ready_out), 32'(rdy && q1.size() < 1));
      chk("valid1", 32'(bus1.dn_valid_out), 32'(rdy && q1.size() != 0));
      chk("data1", bus1.dn_data_out, (rdy && q1.size() != 0) ? q1[0] : 32'h0);
      chk("count1", 32'(cnt1), 32'(q1.size()));
      chk("bubble1", 32'(bub1), b1);
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic dr);
    up_valid = v;
    up_data  = d;
    dn_ready = dr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    up_valid = 1'b1; up_data = 32'hDEADBEEF; dn_ready = 1'b0;
    @(posedge clk); #2;
    mon_en = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst_count2", 32'(cnt2), 32'h0);
    chk("rst_data2", bus2.dn_data_out, 32'h0);
    chk("rst_bubble2", 32'(bub2), 32'h0);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i), 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);

    // Backpressure: fill, offer C while full, then drain.
    drive(1'b1, 32'hA, 1'b0);
    drive(1'b1, 32'hB, 1'b0);
    drive(1'b1, 32'hC, 1'b0);
    drive(1'b1, 32'hC, 1'b1);
    drive(1'b1, 32'hC, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1);

    // Flush with a concurrent push that must be discarded.
    drive(1'b1, 32'h11, 1'b0);
    drive(1'b1, 32'h22, 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'h0BADF00D, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_count2", 32'(cnt2), 32'h0);
    chk("flush_data2", bus2.dn_data_out, 32'h0);
    drive(1'b1, 32'h33, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);

    // Freeze with one entry held.
    drive(1'b1, 32'h44, 1'b0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1);
    rdy = 1'b1;
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);

    // Back-to-back pushes: DEPTH=1 alternates acceptance.
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h100 + 32'(i), 1'b1);

    // Random traffic with occasional freeze, flush and reset.
    for (int i = 0; i < 2000; i++) begin
      rdy   = ($urandom_range(9) != 0);
      flush = ($urandom_range(31) == 0);
      rst_n = ($urandom_range(99) != 0);
      drive(1'($urandom_range(1)), $urandom, 1'($urandom_range(3) != 0));
    end
    rst_n = 1'b1; rdy = 1'b1; flush = 1'b0;

    // Bubble counter saturation.
    mon_en = 1'b0;
    for (int i = 0; i < 65600; i++) drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("sat2", 32'(bub2), 32'hFFFF);
    chk("sat1", 32'(bub1), 32'hFFFF);
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h55, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("sat2_hold", 32'(bub2), 32'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
